// File: rtl/sd_pkg.sv
// Constants shared by the SDIO data-frame transmitter and receiver.
// Lane widths, the default per-lane CRC polynomial and the deframer state codes.
package sd_pkg;

  localparam logic [1:0]  WIDTH_1W = 2'b00;
  localparam logic [1:0]  WIDTH_4W = 2'b01;
  localparam logic [1:0]  WIDTH_8W = 2'b10;

  localparam logic [15:0] DEFAULT_CRC_POLY = 16'h1021;

  localparam logic [2:0]  ST_IDLE       = 3'd0;
  localparam logic [2:0]  ST_WAIT_START = 3'd1;
  localparam logic [2:0]  ST_DATA       = 3'd2;
  localparam logic [2:0]  ST_CRC        = 3'd3;
  localparam logic [2:0]  ST_END        = 3'd4;

  // Width code 2'b11 behaves as 8-lane mode.
  function automatic logic [7:0] lane_mask(input logic [1:0] w);
    case (w)
      WIDTH_1W: return 8'h01;
      WIDTH_4W: return 8'h0F;
      default:  return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] lane_bits(input logic [1:0] w);
    case (w)
      WIDTH_1W: return 4'd1;
      WIDTH_4W: return 4'd4;
      default:  return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/sdrxcrc.sv
// Single-lane serial CRC register, MSB-first shift.
// o_zero reports an all-zero remainder, i.e. data plus appended CRC checked clean.
module sdrxcrc #(
  parameter int              NCRC = 16,
  parameter logic [NCRC-1:0] POLY = 16'h1021
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_step,
  input  logic i_bit,
  output logic o_zero
);

  logic [NCRC-1:0] crc_q;
  logic [NCRC-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (i_clear) begin
      crc_d = '0;
    end else if (i_step) begin
      crc_d = {crc_q[NCRC-2:0], 1'b0} ^ ((crc_q[NCRC-1] ^ i_bit) ? POLY : '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  assign o_zero = (crc_q == '0);

endmodule

// File: rtl/sdrxframe.sv
// SDIO receive data-frame deframer: start-bit search, 1/4/8-lane packing into
// 32-bit words, per-lane CRC-16 and end-bit checking, completion/error report.
module sdrxframe
  import sd_pkg::*;
#(
  parameter int              NCRC           = 16,
  parameter logic [NCRC-1:0] CRC_POLYNOMIAL = 16'h1021,
  parameter int              LGLEN          = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_cfg_width,
  input  logic [LGLEN-1:0] i_length,
  input  logic             i_en,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic             M_VALID,
  output logic [31:0]      M_DATA,
  output logic             M_LAST,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  // Handshake: a sample is consumed on every cycle with i_rx_valid=1 (no ready);
  // M_VALID is a one-cycle strobe with no backpressure, M_DATA/M_LAST qualify it.

  localparam int BW = LGLEN + 3;
  localparam int CW = $clog2(NCRC + 1);

  logic [2:0]       state_q,  state_d;
  logic [1:0]       width_q,  width_d;
  logic [LGLEN-1:0] len_q,    len_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0]    crccnt_q, crccnt_d;
  logic [31:0]      word_q,   word_d;
  logic [31:0]      mdata_q,  mdata_d;
  logic             mvalid_q, mvalid_d;
  logic             mlast_q,  mlast_d;
  logic             done_q,   done_d;
  logic             err_q,    err_d;

  logic [7:0]  mask;
  logic [7:0]  crc_zero;
  logic [BW-1:0] bit_next;
  logic [31:0] word_shift;
  logic        crc_clear;
  logic        crc_step;
  logic        start_bit;
  logic        crc_ok;
  logic        end_ok;
  logic        last_sample;

  assign mask        = lane_mask(width_q);
  assign bit_next    = bitcnt_q + BW'(lane_bits(width_q));
  assign start_bit   = ((i_rx_data & mask) == 8'h00);
  assign crc_ok      = &(crc_zero | ~mask);
  assign end_ok      = &(i_rx_data | ~mask);
  assign last_sample = (bit_next == {len_q, 3'b000});

  always_comb begin
    case (width_q)
      WIDTH_1W: word_shift = {word_q[30:0], i_rx_data[0]};
      WIDTH_4W: word_shift = {word_q[27:0], i_rx_data[3:0]};
      default:  word_shift = {word_q[23:0], i_rx_data};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    len_d     = len_q;
    bitcnt_d  = bitcnt_q;
    crccnt_d  = crccnt_q;
    word_d    = word_q;
    mdata_d   = mdata_q;
    mvalid_d  = 1'b0;
    mlast_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    crc_clear = 1'b0;
    crc_step  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (i_en) begin
        width_d = i_cfg_width;
        len_d   = i_length;
        state_d = ST_WAIT_START;
      end
    end else if (!i_en) begin
      // Abort: drop the frame, including any word completing this cycle.
      state_d = ST_IDLE;
    end else if (i_rx_valid) begin
      case (state_q)
        ST_WAIT_START: begin
          if (start_bit) begin
            crc_clear = 1'b1;
            bitcnt_d  = '0;
            crccnt_d  = '0;
            word_d    = '0;
            err_d     = 1'b0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          crc_step = 1'b1;
          word_d   = word_shift;
          bitcnt_d = bit_next;
          if (bit_next[4:0] == 5'd0) begin
            mvalid_d = 1'b1;
            mdata_d  = word_shift;
            mlast_d  = last_sample;
          end
          if (last_sample) state_d = ST_CRC;
        end
        ST_CRC: begin
          crc_step = 1'b1;
          crccnt_d = crccnt_q + 1'b1;
          if (crccnt_q == CW'(NCRC - 1)) state_d = ST_END;
        end
        ST_END: begin
          done_d  = 1'b1;
          err_d   = !crc_ok || !end_ok;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      width_q  <= '0;
      len_q    <= '0;
      bitcnt_q <= '0;
      crccnt_q <= '0;
      word_q   <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      len_q    <= len_d;
      bitcnt_q <= bitcnt_d;
      crccnt_q <= crccnt_d;
      word_q   <= word_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_lane
    sdrxcrc #(
      .NCRC (NCRC),
      .POLY (CRC_POLYNOMIAL)
    ) u_crc (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (crc_clear),
      .i_step  (crc_step & mask[k]),
      .i_bit   (i_rx_data[k]),
      .o_zero  (crc_zero[k])
    );
  end

  assign M_VALID = mvalid_q;
  assign M_DATA  = mdata_q;
  assign M_LAST  = mlast_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule
